// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display path.
// Character codes are common to the game-status formatter (producer) and
// seg_scan_driver (consumer): 0..9 are decimal digits, 10 is BLANK, 11..35
// are letters, and 36..63 are unassigned and render as BLANK.
// Glyphs are active-low cathode patterns, bit0 = segment a .. bit6 = segment g.
package seg_pkg;

    typedef logic [5:0] char_t;
    typedef logic [6:0] glyph_t;

    localparam glyph_t    CAT_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF = 8'hFF;

    localparam char_t CH_BLANK = 6'd10;
    localparam char_t CH_A     = 6'd11;
    localparam char_t CH_B     = 6'd12;
    localparam char_t CH_C     = 6'd13;
    localparam char_t CH_D     = 6'd14;
    localparam char_t CH_E     = 6'd15;
    localparam char_t CH_F     = 6'd16;
    localparam char_t CH_G     = 6'd17;
    localparam char_t CH_H     = 6'd18;
    localparam char_t CH_I     = 6'd19;
    localparam char_t CH_J     = 6'd20;
    localparam char_t CH_K     = 6'd21;
    localparam char_t CH_L     = 6'd22;
    localparam char_t CH_M     = 6'd23;
    localparam char_t CH_N     = 6'd24;
    localparam char_t CH_O     = 6'd25;
    localparam char_t CH_P     = 6'd26;
    localparam char_t CH_Q     = 6'd27;
    localparam char_t CH_R     = 6'd28;
    localparam char_t CH_S     = 6'd29;
    localparam char_t CH_T     = 6'd30;
    localparam char_t CH_U     = 6'd31;
    localparam char_t CH_V     = 6'd32;
    localparam char_t CH_W     = 6'd33;
    localparam char_t CH_X     = 6'd34;
    localparam char_t CH_Y     = 6'd35;

    // Digit-slot phase: anodes dark during GUARD, one digit lit during ACTIVE.
    typedef enum logic {
        PH_GUARD  = 1'b0,
        PH_ACTIVE = 1'b1
    } phase_t;

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational character-code to 7-segment glyph decoder.
// Ports:
//   i_char   in   6  character code (seg_pkg::char_t)
//   o_glyph  out  7  active-low cathode pattern, bit0 = a .. bit6 = g
// Letters that a 7-segment display cannot draw distinctly reuse a close
// shape: K and X draw as H, M draws as n, V and W draw as U.
module seg_glyph_rom
    import seg_pkg::*;
(
    input  char_t  i_char,
    output glyph_t o_glyph
);

    always_comb begin
        o_glyph = CAT_OFF;
        case (i_char)
            6'd0:     o_glyph = 7'h40;
            6'd1:     o_glyph = 7'h79;
            6'd2:     o_glyph = 7'h24;
            6'd3:     o_glyph = 7'h30;
            6'd4:     o_glyph = 7'h19;
            6'd5:     o_glyph = 7'h12;
            6'd6:     o_glyph = 7'h02;
            6'd7:     o_glyph = 7'h78;
            6'd8:     o_glyph = 7'h00;
            6'd9:     o_glyph = 7'h10;
            CH_BLANK: o_glyph = CAT_OFF;
            CH_A:     o_glyph = 7'h08;
            CH_B:     o_glyph = 7'h03;
            CH_C:     o_glyph = 7'h46;
            CH_D:     o_glyph = 7'h21;
            CH_E:     o_glyph = 7'h06;
            CH_F:     o_glyph = 7'h0E;
            CH_G:     o_glyph = 7'h42;
            CH_H:     o_glyph = 7'h09;
            CH_I:     o_glyph = 7'h4F;
            CH_J:     o_glyph = 7'h61;
            CH_K:     o_glyph = 7'h09;
            CH_L:     o_glyph = 7'h47;
            CH_M:     o_glyph = 7'h2B;
            CH_N:     o_glyph = 7'h2B;
            CH_O:     o_glyph = 7'h40;
            CH_P:     o_glyph = 7'h0C;
            CH_Q:     o_glyph = 7'h18;
            CH_R:     o_glyph = 7'h2F;
            CH_S:     o_glyph = 7'h12;
            CH_T:     o_glyph = 7'h07;
            CH_U:     o_glyph = 7'h41;
            CH_V:     o_glyph = 7'h41;
            CH_W:     o_glyph = 7'h41;
            CH_X:     o_glyph = 7'h09;
            CH_Y:     o_glyph = 7'h11;
            default:  o_glyph = CAT_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// Each digit owns SCAN_DIV clock cycles; the first GUARD_CYC cycles of a
// slot keep every anode off so the previous digit's cathodes cannot ghost
// onto the next one. The character buffer is copied once per frame so a
// frame never mixes old and new text, and the whole display can blink with
// a half-period of BLINK_FRAMES frames.
// Ports:
//   clk_in       in   1      system clock
//   rst_in       in   1      synchronous, active-high reset
//   char_in      in   8x6    char codes, char_in[i] drives an_out[i]
//   blink_en_in  in   1      1 = blink whole display
//   cat_out      out  7      cathodes, active-low, bit0 = a .. bit6 = g
//   an_out       out  8      anodes, active-low, at most one bit low
//   frame_out    out  1      1-cycle pulse when a new snapshot is taken
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 100_000,
    parameter int GUARD_CYC    = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  char_t      char_in [7:0],
    input  logic       blink_en_in,
    output glyph_t     cat_out,
    output logic [7:0] an_out,
    output logic       frame_out
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] GUARD_V = DIV_W'(GUARD_CYC);
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [2:0]       r_digit;
    logic [BLK_W-1:0] r_blink_cnt;
    logic             r_blink_off;
    logic             r_first;
    logic             r_frame;
    char_t            r_snap [7:0];
    logic [7:0]       r_an;
    glyph_t           r_cat;
    phase_t           r_phase;

    logic [DIV_W-1:0] w_div_nxt;
    logic             w_div_wrap;
    logic             w_frame_end;
    logic             w_blink_wrap;
    logic             w_snap_take;
    phase_t           w_phase_nxt;
    logic [7:0]       w_an_nxt;
    glyph_t           w_cat_nxt;
    glyph_t           w_glyph;

    assign w_div_wrap   = (r_div_cnt == DIV_MAX);
    assign w_div_nxt    = w_div_wrap ? '0 : r_div_cnt + 1'b1;
    assign w_frame_end  = w_div_wrap && (r_digit == 3'd7);
    assign w_blink_wrap = (r_blink_cnt == BLK_MAX);
    // The first cycle out of reset also loads the buffer, so the display
    // does not sit blank for a whole frame after reset.
    assign w_snap_take  = w_frame_end || r_first;

    seg_glyph_rom u_glyph_rom (
        .i_char  (r_snap[r_digit]),
        .o_glyph (w_glyph)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_phase <= PH_GUARD;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    // Phase tracks the counter value being loaded, so r_phase always agrees
    // with r_div_cnt; the output registers below then add one cycle of latency.
    always_comb begin
        w_phase_nxt = (w_div_nxt < GUARD_V) ? PH_GUARD : PH_ACTIVE;
        w_an_nxt    = AN_OFF;
        w_cat_nxt   = CAT_OFF;
        if (r_phase == PH_ACTIVE && !(blink_en_in && r_blink_off)) begin
            w_an_nxt          = AN_OFF;
            w_an_nxt[r_digit] = 1'b0;
            w_cat_nxt         = w_glyph;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_div_cnt   <= '0;
            r_digit     <= '0;
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
            r_first     <= 1'b1;
            r_frame     <= 1'b0;
            r_an        <= AN_OFF;
            r_cat       <= CAT_OFF;
            for (int i = 0; i < 8; i++) begin
                r_snap[i] <= CH_BLANK;
            end
        end else begin
            r_div_cnt <= w_div_nxt;
            if (w_div_wrap) begin
                r_digit <= r_digit + 1'b1;
            end
            // Blink phase keeps counting even while blinking is disabled.
            if (w_frame_end) begin
                r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
                if (w_blink_wrap) begin
                    r_blink_off <= ~r_blink_off;
                end
            end
            r_first <= 1'b0;
            r_frame <= w_snap_take;
            if (w_snap_take) begin
                r_snap <= char_in;
            end
            r_an  <= w_an_nxt;
            r_cat <= w_cat_nxt;
        end
    end

    assign an_out    = r_an;
    assign cat_out   = r_cat;
    assign frame_out = r_frame;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;
    import seg_pkg::*;

    localparam int SD = 8;
    localparam int G  = 2;
    localparam int BF = 2;
    localparam int FRAME = SD * 8;

    logic       clk = 1'b0;
    logic       rst_in;
    char_t      chars [7:0];
    logic       blink_en;
    glyph_t     cat_out;
    logic [7:0] an_out;
    logic       frame_out;

    char_t      rom_char;
    glyph_t     rom_glyph;

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;        // cycles since reset release
    char_t m_snap [7:0];

    // Lit segments of each code, by segment letter.
    string SEGS [0:35] = '{
        "abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
        "abcdefg", "abcdfg", "",
        "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg", "acdef", "bcefg",
        "ef", "bcde", "bcefg", "def", "ceg", "ceg", "abcdef", "abefg",
        "abcfg", "eg", "acdfg", "defg", "bcdef", "bcdef", "bcdef", "bcefg",
        "bcdfg"
    };

    seg_scan_driver #(
        .SCAN_DIV     (SD),
        .GUARD_CYC    (G),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk_in      (clk),
        .rst_in      (rst_in),
        .char_in     (chars),
        .blink_en_in (blink_en),
        .cat_out     (cat_out),
        .an_out      (an_out),
        .frame_out   (frame_out)
    );

    seg_glyph_rom u_rom (
        .i_char  (rom_char),
        .o_glyph (rom_glyph)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_glyph(input int code);
        logic [6:0] hi;
        string s;
        hi = '0;
        s  = (code < 36) ? SEGS[code] : "";
        for (int i = 0; i < s.len(); i++) begin
            hi[int'(s[i]) - 97] = 1'b1;
        end
        return ~hi;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s (k=%0d): got %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic randomize_chars();
        for (int i = 0; i < 8; i++) chars[i] = char_t'($urandom_range(0, 63));
    endtask

    // One clock: predict outputs for this edge, then compare 1 time unit later.
    task automatic step();
        int dv, dg, fr;
        logic boff;
        logic [7:0] ea;
        logic [6:0] ec;
        logic ef;
        @(posedge clk);
        ea = 8'hFF;
        ec = 7'h7F;
        ef = 1'b0;
        if (rst_in) begin
            k = 0;
            for (int i = 0; i < 8; i++) m_snap[i] = CH_BLANK;
        end else begin
            dv   = k % SD;
            dg   = (k / SD) % 8;
            fr   = k / FRAME;
            boff = ((fr / BF) % 2) == 1;
            if (dv >= G && !(blink_en && boff)) begin
                ea = ~(8'd1 << dg);
                ec = ref_glyph(int'(m_snap[dg]));
            end
            ef = (k == 0) || (k % FRAME == FRAME - 1);
            if (ef) m_snap = chars;
            k++;
        end
        #1;
        chk("an_out", an_out, ea);
        chk("cat_out", {1'b0, cat_out}, {1'b0, ec});
        chk("frame_out", {7'd0, frame_out}, {7'd0, ef});
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (k < target && guard < 20000) begin
            step();
            guard++;
        end
        n_tests++;
        assert (k == target)
        else begin
            n_fail++;
            $error("FAIL run_to: reached %0d expected %0d", k, target);
        end
    endtask

    initial begin
        rst_in   = 1'b1;
        blink_en = 1'b0;
        rom_char = '0;
        randomize_chars();
        for (int i = 0; i < 8; i++) m_snap[i] = CH_BLANK;

        repeat (3) step();

        chars[7] = CH_P; chars[6] = CH_A; chars[5] = CH_S; chars[4] = CH_S;
        chars[3] = CH_E; chars[2] = CH_D; chars[1] = CH_BLANK; chars[0] = CH_BLANK;
        rst_in = 1'b0;

        run_to(19);
        chk("d2_an", an_out, 8'hFB);
        chk("d2_cat", {1'b0, cat_out}, 8'h21);
        run_to(59);
        chk("d7_an", an_out, 8'h7F);
        chk("d7_cat", {1'b0, cat_out}, 8'h0C);

        run_to(FRAME + 3 * SD + 3);
        randomize_chars();
        run_to(3 * FRAME);

        blink_en = 1'b1;
        run_to(11 * FRAME + 20);
        blink_en = 1'b0;
        run_to(12 * FRAME);

        repeat (6 * FRAME) begin
            step();
            if ($urandom_range(0, 15) == 0) randomize_chars();
            if ($urandom_range(0, 63) == 0) blink_en = ~blink_en;
        end

        blink_en = 1'b0;
        run_to((k / FRAME + 1) * FRAME + 5 * SD + 4);
        rst_in = 1'b1;
        step();
        chk("rst_mid_an", an_out, 8'hFF);
        rst_in = 1'b0;
        randomize_chars();
        run_to(2 * FRAME);

        for (int c = 0; c < 64; c++) begin
            rom_char = char_t'(c);
            #1;
            chk($sformatf("rom_%0d", c), {1'b0, rom_glyph}, {1'b0, ref_glyph(c)});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
